// File: rtl/spi_simple_pkg.sv
// Shared definitions for the SPI byte-bus subsystem: byte width, framing
// states and default bus addresses of the built-in clients.
package spi_simple_pkg;

  localparam int         BYTE_W        = 8;
  localparam logic [7:0] DEF_REG_ADDR  = 8'hA5;
  localparam int         DEF_REG_BYTES = 2;
  localparam logic [7:0] DEF_PKT_BASE  = 8'hA4;

  // Transaction framing: waiting for CS, expecting the address byte, data bytes.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/spi_simple_phy.sv
// SPI mode-0 slave physical layer: synchronises the asynchronous SPI pins into
// clk, detects spi_clk/cs_n edges, assembles MOSI bytes (MSB first) and drives
// MISO from a shift register loaded with tx_byte at the start of every byte.
// Synchroniser flops reset low so that a reset released while cs_n is already
// low does not look like a fresh chip-select fall.
module spi_simple_phy import spi_simple_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  input  logic [BYTE_W-1:0] tx_byte,
  output logic              byte_done,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              cs_fall,
  output logic              cs_rise
);

  logic [1:0] sclk_s, mosi_s, cs_s;
  logic       sclk_q, cs_q;
  logic       sclk, mosi, cs_n;
  logic       sclk_rise, sclk_fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [7:0] tx_sr;

  assign sclk      = sclk_s[1];
  assign mosi      = mosi_s[1];
  assign cs_n      = cs_s[1];
  assign sclk_rise = sclk & ~sclk_q;
  assign sclk_fall = ~sclk & sclk_q;
  assign cs_fall   = ~cs_n & cs_q;
  assign cs_rise   = cs_n & ~cs_q;
  assign spi_miso  = tx_sr[7];

  // Two-flop synchronisers plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_s <= '0;
      mosi_s <= '0;
      cs_s   <= '0;
      sclk_q <= 1'b0;
      cs_q   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], spi_clk};
      mosi_s <= {mosi_s[0], spi_mosi};
      cs_s   <= {cs_s[0], spi_cs_n};
      sclk_q <= sclk;
      cs_q   <= cs_n;
    end
  end

  // Receive: shift MOSI on each spi_clk rise, pulse byte_done on the 8th bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_sr     <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (cs_n) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        rx_sr   <= {rx_sr[5:0], mosi};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_byte   <= {rx_sr, mosi};
        end
      end
    end
  end

  // Transmit: load tx_byte at CS fall and after each full byte, shift on spi_clk fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr <= '0;
    end else if (cs_n) begin
      tx_sr <= '0;
    end else if (cs_fall) begin
      tx_sr <= tx_byte;
    end else if (sclk_fall) begin
      if (bit_cnt == 3'd0) tx_sr <= tx_byte;
      else                 tx_sr <= {tx_sr[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_simple_subsys.sv
// SPI slave subsystem: frames each CS-low transaction as one address byte plus
// data bytes, broadcasts data bytes on a registered byte bus and feeds a
// multi-byte control register and (with PKT_FIFO_EN defined) a FIFO packet writer.
//
// Bus semantics: strobe is a single-cycle valid with no back-pressure; addr,
// data, first and last are meaningful in the strobe cycle. The FIFO port writes
// when fifo_wren is high and only if fifo_full was low in that same cycle;
// a byte arriving while fifo_full is high is dropped.
module spi_simple_subsys import spi_simple_pkg::*; #(
  parameter logic [7:0] REG_ADDR  = DEF_REG_ADDR,
  parameter int         REG_BYTES = DEF_REG_BYTES,
  parameter logic [7:0] PKT_BASE  = DEF_PKT_BASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  input  logic                   spi_cs_n,
  input  logic                   spi_clk,
  input  logic [7:0]             out,
  output logic [7:0]             addr,
  output logic [7:0]             data,
  output logic                   first,
  output logic                   last,
  output logic                   strobe,
  input  logic [8*REG_BYTES-1:0] rst_val,
  output logic [8*REG_BYTES-1:0] out_val,
  output logic                   out_stb,
  output logic [7:0]             fifo_data,
  output logic                   fifo_last,
  output logic                   fifo_wren,
  input  logic                   fifo_full
);

  localparam int VW = BYTE_W * REG_BYTES;

  state_t     state, next_state;
  logic       byte_done, cs_fall, cs_rise;
  logic [7:0] rx_byte;
  logic       take_addr, push_byte, flush;
  logic [7:0] pend_data;
  logic       pend_valid, first_pend;

  spi_simple_phy u_phy (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .spi_miso  (spi_miso),
    .tx_byte   (out),
    .byte_done (byte_done),
    .rx_byte   (rx_byte),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  // Framing state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and per-cycle framing actions.
  always_comb begin
    next_state = state;
    take_addr  = 1'b0;
    push_byte  = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: if (cs_fall) next_state = ADDR;
      ADDR: begin
        if (cs_rise) next_state = IDLE;
        else if (byte_done) begin
          take_addr  = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        if (cs_rise) begin
          flush      = 1'b1;
          next_state = IDLE;
        end else if (byte_done) begin
          push_byte = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Byte bus: hold each data byte until we know whether it is the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      data       <= '0;
      first      <= 1'b0;
      last       <= 1'b0;
      strobe     <= 1'b0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      first_pend <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (cs_fall) begin
        pend_valid <= 1'b0;
        first_pend <= 1'b1;
      end
      if (take_addr) addr <= rx_byte;
      if (push_byte) begin
        pend_data  <= rx_byte;
        pend_valid <= 1'b1;
        if (pend_valid) begin
          strobe     <= 1'b1;
          data       <= pend_data;
          first      <= first_pend;
          last       <= 1'b0;
          first_pend <= 1'b0;
        end
      end
      if (flush && pend_valid) begin
        strobe     <= 1'b1;
        data       <= pend_data;
        first      <= first_pend;
        last       <= 1'b1;
        pend_valid <= 1'b0;
      end
    end
  end

  // Control register client: accumulate MSB byte first, commit after REG_BYTES bytes.
  logic [VW-1:0] acc, acc_base, acc_next;
  logic [2:0]    rcnt, cnt_base, cnt_next;
  logic          reg_hit;

  // Accumulator update for the byte currently on the bus.
  always_comb begin
    acc_base = first ? '0 : acc;
    cnt_base = first ? 3'd0 : rcnt;
    acc_next = (acc_base << 8) | VW'(data);
    cnt_next = cnt_base + 3'd1;
    reg_hit  = strobe && (addr == REG_ADDR) && (first || (rcnt < 3'(REG_BYTES)));
  end

  // Register storage; extra bytes are ignored and short transactions never commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      rcnt    <= '0;
      out_val <= rst_val;
      out_stb <= 1'b0;
    end else begin
      out_stb <= 1'b0;
      if (reg_hit) begin
        acc  <= acc_next;
        rcnt <= cnt_next;
        if (cnt_next == 3'(REG_BYTES)) begin
          out_val <= acc_next;
          out_stb <= 1'b1;
        end
      end
    end
  end

`ifdef PKT_FIFO_EN
  // Packet writer: forward bus bytes for PKT_BASE straight to the FIFO port.
  always_comb begin
    fifo_wren = strobe && (addr == PKT_BASE) && !fifo_full;
    fifo_data = fifo_wren ? data : 8'h00;
    fifo_last = fifo_wren && last;
  end
`else
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;
  assign fifo_wren        = 1'b0;
  assign fifo_data        = 8'h00;
  assign fifo_last        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_simple_subsys.sv
// Bench for spi_simple_subsys: table of SPI transactions plus hand-written
// partial-byte and mid-transaction reset sequences.
module tb_spi_simple_subsys;

  localparam int HALF = 32;
`ifdef PKT_FIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clk, rst;
  logic        spi_mosi, spi_miso, spi_cs_n, spi_clk;
  logic [7:0]  out, addr, data;
  logic        first, last, strobe;
  logic [15:0] rst_val, out_val;
  logic        out_stb;
  logic [7:0]  fifo_data;
  logic        fifo_last, fifo_wren, fifo_full;

  spi_simple_subsys #(.REG_ADDR(8'hA5), .REG_BYTES(2), .PKT_BASE(8'hA4)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_cs_n  (spi_cs_n),
    .spi_clk   (spi_clk),
    .out       (out),
    .addr      (addr),
    .data      (data),
    .first     (first),
    .last      (last),
    .strobe    (strobe),
    .rst_val   (rst_val),
    .out_val   (out_val),
    .out_stb   (out_stb),
    .fifo_data (fifo_data),
    .fifo_last (fifo_last),
    .fifo_wren (fifo_wren),
    .fifo_full (fifo_full)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  int stb_cnt = 0;
  int bus_cnt = 0;
  logic [17:0] exp_q[$];   // {addr, data, first, last}
  logic [8:0]  fifo_q[$];  // {data, last}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Compare every bus strobe and FIFO write against the expected queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (strobe) begin
        bus_cnt++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL bus_unexpected: got addr %0h data %0h first %0b last %0b, expected no strobe",
                   addr, data, first, last);
        end else begin
          check("bus_item", 32'({addr, data, first, last}), 32'(exp_q.pop_front()));
        end
      end
      if (fifo_wren) begin
        if (fifo_q.size() == 0) begin
          n_total++;
          $display("FAIL fifo_unexpected: got data %0h last %0b, expected no write", fifo_data, fifo_last);
        end else begin
          check("fifo_item", 32'({fifo_data, fifo_last}), 32'(fifo_q.pop_front()));
        end
      end
      if (out_stb) stb_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (HALF) @(posedge clk);
    #1 m = spi_miso;
    spi_clk = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 spi_clk = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit chk_miso);
    logic [7:0] rx;
    logic       m;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(b[7-i], m);
      rx = {rx[6:0], m};
    end
    if (chk_miso) check("miso_byte", 32'(rx), 32'h000000BA);
  endtask

  task automatic cs_start();
    spi_cs_n = 1'b0;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(posedge clk);
    #1 spi_cs_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0][7:0] b;       // b[0] is the address byte
    logic [2:0]      nbytes;
    logic            full;
    logic [15:0]     exp_val;
    logic            exp_upd;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] d1, input logic [7:0] d2,
                              input logic [7:0] d3, input logic [2:0] n, input logic full,
                              input logic [15:0] val, input logic upd);
    vec_t v;
    v.b       = {d3, d2, d1, a};
    v.nbytes  = n;
    v.full    = full;
    v.exp_val = val;
    v.exp_upd = upd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] a;
    int n;
    a = v.b[0];
    n = int'(v.nbytes);
    stb_cnt = 0;
    for (int i = 1; i < n; i++) begin
      exp_q.push_back({a, v.b[i], (i == 1), (i == n - 1)});
      if (FIFO_EN && a == 8'hA4 && !v.full) fifo_q.push_back({v.b[i], (i == n - 1)});
    end
    fifo_full = v.full;
    cs_start();
    for (int i = 0; i < n; i++) spi_bits(v.b[i], 8, 1'b1);
    cs_end();
    check($sformatf("bus_drain_v%0d", idx), 32'(exp_q.size()), 32'd0);
    check($sformatf("fifo_drain_v%0d", idx), 32'(fifo_q.size()), 32'd0);
    check($sformatf("out_val_v%0d", idx), 32'(out_val), 32'(v.exp_val));
    check($sformatf("out_stb_v%0d", idx), 32'(stb_cnt), 32'(v.exp_upd));
    exp_q.delete();
    fifo_q.delete();
    fifo_full = 1'b0;
  endtask

  vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = mk(8'hA5, 8'hC1, 8'h00, 8'h00, 3'd2, 1'b0, 16'hBABE, 1'b0); // short: no update
    vecs[1] = mk(8'hA5, 8'hC1, 8'hC2, 8'h00, 3'd3, 1'b0, 16'hC1C2, 1'b1);
    vecs[2] = mk(8'hA4, 8'h11, 8'h22, 8'h33, 3'd4, 1'b0, 16'hC1C2, 1'b0);
    vecs[3] = mk(8'hA4, 8'h11, 8'h22, 8'h00, 3'd3, 1'b1, 16'hC1C2, 1'b0); // FIFO full
    vecs[4] = mk(8'hA5, 8'hDE, 8'hAD, 8'hBE, 3'd4, 1'b0, 16'hDEAD, 1'b1); // extra byte ignored
    vecs[5] = mk(8'hA5, 8'h00, 8'h00, 8'h00, 3'd1, 1'b0, 16'hDEAD, 1'b0); // address only
    vecs[6] = mk(8'h3C, 8'h55, 8'h66, 8'h00, 3'd3, 1'b0, 16'hDEAD, 1'b0); // foreign address

    rst       = 1'b1;
    spi_mosi  = 1'b0;
    spi_cs_n  = 1'b1;
    spi_clk   = 1'b0;
    out       = 8'hBA;
    rst_val   = 16'hBABE;
    fifo_full = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_addr",    32'(addr),      32'h0);
    check("rst_data",    32'(data),      32'h0);
    check("rst_flags",   32'({first, last, strobe, out_stb}), 32'h0);
    check("rst_miso",    32'(spi_miso),  32'h0);
    check("rst_out_val", 32'(out_val),   32'hBABE);
    check("rst_fifo",    32'({fifo_data, fifo_last, fifo_wren}), 32'h0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Partial trailing byte is discarded: single strobe with first=last=1.
    stb_cnt = 0;
    exp_q.push_back({8'hA5, 8'hC1, 1'b1, 1'b1});
    cs_start();
    spi_bits(8'hA5, 8, 1'b1);
    spi_bits(8'hC1, 8, 1'b1);
    spi_bits(8'hFF, 4, 1'b0);
    cs_end();
    check("partial_drain",   32'(exp_q.size()), 32'd0);
    check("partial_out_val", 32'(out_val),      32'hDEAD);
    check("partial_out_stb", 32'(stb_cnt),      32'd0);
    exp_q.delete();

    // Reset in the middle of a transaction: nothing resumes until the next CS fall.
    cs_start();
    spi_bits(8'hA5, 8, 1'b1);
    spi_bits(8'h99, 3, 1'b0);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_out_val", 32'(out_val), 32'hBABE);
    check("midrst_addr",    32'(addr),    32'h0);
    rst = 1'b0;
    bus_cnt = 0;
    stb_cnt = 0;
    spi_bits(8'h99, 5, 1'b0);
    spi_bits(8'h77, 8, 1'b0);
    spi_bits(8'h66, 8, 1'b0);
    cs_end();
    check("midrst_no_strobe", 32'(bus_cnt), 32'd0);
    check("midrst_no_update", 32'(stb_cnt), 32'd0);
    check("midrst_hold_val",  32'(out_val), 32'hBABE);

    run_vec(mk(8'hA5, 8'h12, 8'h34, 8'h00, 3'd3, 1'b0, 16'h1234, 1'b1), 7);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
